// File: rtl/udp_dispatch_pkg.sv
// Shared types for the UDP destination-port dispatch controller:
// FSM state encoding, port-table entry layout and counter sizing.
package udp_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic        en;
    logic [15:0] port;
  } entry_t;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Select width never collapses to zero, even for a single output.
  function automatic int sel_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority match of a UDP port against the enabled table
// entries; the lowest matching index wins. The parent registers the result.
module udp_port_match
  import udp_dispatch_pkg::*;
#(
  parameter int M_COUNT = 2,
  parameter int SEL_W   = sel_width(M_COUNT)
) (
  input  logic [15:0]      port,
  input  entry_t           entries [M_COUNT],
  output logic             hit,
  output logic [SEL_W-1:0] index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      if (!hit && entries[i].en && (entries[i].port == port)) begin
        hit   = 1'b1;
        index = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/udp_port_dispatch_ctrl.sv
// Steers the UDP RX demux: snoops the sink header, looks the destination port
// up in a programmable table and holds enable/select/drop for one datagram.
//
// Handshake rule: a header or payload beat transfers only on a clock edge where
// its valid and ready are both high; this block only observes, never stalls.
module udp_port_dispatch_ctrl
  import udp_dispatch_pkg::*;
#(
  parameter  int M_COUNT        = 2,
  parameter  int DROP_UNMATCHED = 1,
  parameter  int DEFAULT_SELECT = 0,
  localparam int SEL_W          = sel_width(M_COUNT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hdr_valid,
  input  logic             hdr_ready,
  input  logic [15:0]      dest_port,
  input  logic             tvalid,
  input  logic             tready,
  input  logic             tlast,
  output logic             enable,
  output logic             drop,
  output logic [SEL_W-1:0] select,
  input  logic             cfg_wr_en,
  input  logic [SEL_W-1:0] cfg_index,
  input  logic [15:0]      cfg_port,
  input  logic             cfg_entry_en,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy,
  output state_t           state_dbg
);

  // Assertion is asynchronous; release is re-timed to clk so every flop
  // below leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  state_t           state_q, state_d;
  logic [15:0]      port_q;
  logic             hdr_done_q, hdr_done_d;
  logic             enable_d, drop_d;
  logic [SEL_W-1:0] select_d;
  logic [CNT_W-1:0] drop_count_d;
  entry_t           tbl [M_COUNT];
  logic             hit;
  logic [SEL_W-1:0] hit_index;
  logic             hdr_fire;
  logic             frame_end;

  udp_port_match #(
    .M_COUNT (M_COUNT),
    .SEL_W   (SEL_W)
  ) u_match (
    .port    (port_q),
    .entries (tbl),
    .hit     (hit),
    .index   (hit_index)
  );

  assign hdr_fire  = hdr_valid && hdr_ready;
  // A tlast beat only closes the datagram once its header has gone through.
  assign frame_end = tvalid && tready && tlast && (hdr_done_q || hdr_fire);

  always_comb begin
    state_d      = state_q;
    enable_d     = enable;
    drop_d       = drop;
    select_d     = select;
    hdr_done_d   = hdr_done_q;
    drop_count_d = drop_count;
    case (state_q)
      IDLE: begin
        enable_d   = 1'b0;
        hdr_done_d = 1'b0;
        if (hdr_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          select_d = hit_index;
          drop_d   = 1'b0;
        end else if (DROP_UNMATCHED != 0) begin
          select_d = '0;
          drop_d   = 1'b1;
        end else begin
          select_d = SEL_W'(DEFAULT_SELECT);
          drop_d   = 1'b0;
        end
        enable_d = 1'b1;
        state_d  = ACTIVE;
      end
      ACTIVE: begin
        if (hdr_fire) hdr_done_d = 1'b1;
        if (frame_end) begin
          enable_d   = 1'b0;
          drop_d     = 1'b0;
          hdr_done_d = 1'b0;
          state_d    = IDLE;
          if (drop && (drop_count != CNT_MAX)) drop_count_d = drop_count + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      enable     <= 1'b0;
      drop       <= 1'b0;
      select     <= '0;
      hdr_done_q <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q    <= state_d;
      enable     <= enable_d;
      drop       <= drop_d;
      select     <= select_d;
      hdr_done_q <= hdr_done_d;
      drop_count <= drop_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                        port_q <= '0;
    else if ((state_q == IDLE) && hdr_valid) port_q <= dest_port;
  end

  // Indices with no matching slot (>= M_COUNT) fall through untouched.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < M_COUNT; i++) tbl[i] <= '0;
    end else begin
      for (int i = 0; i < M_COUNT; i++) begin
        if (cfg_wr_en && (cfg_index == SEL_W'(i))) begin
          tbl[i].en   <= cfg_entry_en;
          tbl[i].port <= cfg_port;
        end
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_udp_port_dispatch_ctrl.sv
// Directed bench for udp_port_dispatch_ctrl: a drop-unmatched instance and a
// forward-unmatched instance (DEFAULT_SELECT=1) share every input.
module tb_udp_port_dispatch_ctrl;
  import udp_dispatch_pkg::*;

  localparam int SEL_W = 1;
  localparam int EW    = 2 * (SEL_W + 1);

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             hdr_valid = 0, hdr_ready = 0;
  logic [15:0]      dest_port = '0;
  logic             tvalid = 0, tready = 0, tlast = 0;
  logic             cfg_wr_en = 0, cfg_entry_en = 0;
  logic [SEL_W-1:0] cfg_index = '0;
  logic [15:0]      cfg_port = '0;

  logic             enable_a, drop_a, busy_a;
  logic [SEL_W-1:0] select_a;
  logic [31:0]      drop_count_a;
  state_t           state_a;
  logic             enable_b, drop_b, busy_b;
  logic [SEL_W-1:0] select_b;
  logic [31:0]      drop_count_b;
  state_t           state_b;

  udp_port_dispatch_ctrl #(.M_COUNT(2), .DROP_UNMATCHED(1), .DEFAULT_SELECT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .dest_port(dest_port), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .enable(enable_a), .drop(drop_a), .select(select_a), .cfg_wr_en(cfg_wr_en),
    .cfg_index(cfg_index), .cfg_port(cfg_port), .cfg_entry_en(cfg_entry_en),
    .drop_count(drop_count_a), .busy(busy_a), .state_dbg(state_a)
  );

  udp_port_dispatch_ctrl #(.M_COUNT(2), .DROP_UNMATCHED(0), .DEFAULT_SELECT(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .dest_port(dest_port), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .enable(enable_b), .drop(drop_b), .select(select_b), .cfg_wr_en(cfg_wr_en),
    .cfg_index(cfg_index), .cfg_port(cfg_port), .cfg_entry_en(cfg_entry_en),
    .drop_count(drop_count_b), .busy(busy_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  int          vec_count  = 0;
  int          miss_count = 0;
  logic [31:0] exp_cnt_a  = 0;
  // Each entry: {drop_a, select_a, drop_b, select_b} expected once enable rises.
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [SEL_W-1:0] idx, input logic [15:0] port, input logic en);
    cfg_wr_en = 1; cfg_index = idx; cfg_port = port; cfg_entry_en = en;
    step();
    cfg_wr_en = 0;
  endtask

  task automatic open_hdr(input logic [15:0] dest, input string tag);
    logic [EW-1:0] e;
    int lat;
    hdr_valid = 1; dest_port = dest; lat = 0;
    do begin
      step();
      lat++;
    end while (!enable_a && lat < 8);
    chk({tag, ".latency"}, 32'(lat), 32'd2);
    chk({tag, ".enable_b"}, {31'b0, enable_b}, 32'd1);
    if (exp_q.size() == 0) begin
      vec_count++;
      miss_count++;
      $display("FAIL %s.scoreboard: got empty expect queue, expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".drop_a"},   {31'b0, drop_a},   {31'b0, e[3]});
      chk({tag, ".select_a"}, {31'b0, select_a}, {31'b0, e[2]});
      chk({tag, ".drop_b"},   {31'b0, drop_b},   {31'b0, e[1]});
      chk({tag, ".select_b"}, {31'b0, select_b}, {31'b0, e[0]});
    end
  endtask

  task automatic hdr_xfer();
    hdr_valid = 1; hdr_ready = 1;
    step();
    hdr_valid = 0; hdr_ready = 0;
  endtask

  task automatic payload(input int beats, input bit stall, input string tag);
    bit held = 1;
    for (int b = 0; b < beats; b++) begin
      tvalid = 1; tlast = (b == beats - 1);
      if (stall) begin
        tready = 0;
        step();
        if (!enable_a) held = 0;
      end
      tready = 1;
      step();
      if ((b != beats - 1) && !enable_a) held = 0;
    end
    tvalid = 0; tready = 0; tlast = 0;
    chk({tag, ".enable_held"}, {31'b0, held}, 32'd1);
    chk({tag, ".enable_fall"}, {31'b0, enable_a}, 32'd0);
    chk({tag, ".enable_b_fall"}, {31'b0, enable_b}, 32'd0);
    chk({tag, ".drop_clear"}, {31'b0, drop_a}, 32'd0);
    chk({tag, ".busy_idle"}, {31'b0, busy_a}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [15:0] p0; logic e0;
    logic [15:0] p1; logic e1;
    logic [15:0] dest;
    int          beats;
    logic        drop_a; logic sel_a;
    logic        drop_b; logic sel_b;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"match1",    16'd5000,  1, 16'd6000, 1, 16'd6000,  4, 0, 1, 0, 1};
    vecs[1] = '{"nomatch",   16'd5000,  1, 16'd6000, 1, 16'd7000,  2, 1, 0, 0, 1};
    vecs[2] = '{"dup_low",   16'd5000,  1, 16'd5000, 1, 16'd5000,  1, 0, 0, 0, 0};
    vecs[3] = '{"dup_dis0",  16'd5000,  0, 16'd5000, 1, 16'd5000,  3, 0, 1, 0, 1};
    vecs[4] = '{"match0",    16'd5000,  1, 16'd6000, 1, 16'd5000,  2, 0, 0, 0, 0};
    vecs[5] = '{"port0_dis", 16'd0,     0, 16'd0,    0, 16'd0,     1, 1, 0, 0, 1};
    vecs[6] = '{"max_port",  16'd65535, 1, 16'd1,    1, 16'd65535, 1, 0, 0, 0, 0};
    vecs[7] = '{"near_miss", 16'd4999,  1, 16'd5001, 1, 16'd5000,  2, 1, 0, 0, 1};

    // reset state
    step(); step();
    chk("rst.enable", {31'b0, enable_a}, 32'd0);
    chk("rst.drop", {31'b0, drop_a}, 32'd0);
    chk("rst.select", {31'b0, select_a}, 32'd0);
    chk("rst.drop_count", drop_count_a, 32'd0);
    chk("rst.busy", {31'b0, busy_a}, 32'd0);
    chk("rst.state", 32'(state_a), 32'(IDLE));
    reset_n = 1;
    step(); step(); step();

    for (int i = 0; i < 8; i++) begin
      cfg_write(1'b0, vecs[i].p0, vecs[i].e0);
      cfg_write(1'b1, vecs[i].p1, vecs[i].e1);
      exp_q.push_back({vecs[i].drop_a, vecs[i].sel_a, vecs[i].drop_b, vecs[i].sel_b});
      open_hdr(vecs[i].dest, vecs[i].name);
      hdr_xfer();
      payload(vecs[i].beats, 0, vecs[i].name);
      if (vecs[i].drop_a) exp_cnt_a++;
      chk({vecs[i].name, ".count_a"}, drop_count_a, exp_cnt_a);
      chk({vecs[i].name, ".count_b"}, drop_count_b, 32'd0);
    end

    // mid-datagram table write leaves the decision alone
    cfg_write(1'b0, 16'd5000, 1);
    cfg_write(1'b1, 16'd6000, 1);
    exp_q.push_back(4'b0101);
    open_hdr(16'd6000, "midwr");
    hdr_xfer();
    cfg_write(1'b1, 16'd7000, 1);
    chk("midwr.select_held", {31'b0, select_a}, 32'd1);
    chk("midwr.enable_held", {31'b0, enable_a}, 32'd1);
    payload(3, 0, "midwr");
    exp_q.push_back(4'b1001);
    open_hdr(16'd6000, "midwr_next");
    hdr_xfer();
    payload(2, 0, "midwr_next");
    exp_cnt_a++;
    chk("midwr_next.count_a", drop_count_a, exp_cnt_a);

    // back-to-back headers with a stalling payload
    cfg_write(1'b1, 16'd6000, 1);
    exp_q.push_back(4'b0000);
    open_hdr(16'd5000, "b2b_first");
    hdr_xfer();
    hdr_valid = 1; dest_port = 16'd6000;
    payload(4, 1, "b2b_first");
    chk("b2b.idle_gap", 32'(state_a), 32'(IDLE));
    exp_q.push_back(4'b0101);
    open_hdr(16'd6000, "b2b_second");
    hdr_xfer();
    payload(1, 0, "b2b_second");

    // a write landing on the LOOKUP edge is not seen by that lookup
    hdr_valid = 1; dest_port = 16'd5000;
    step();
    chk("lkwr.state", 32'(state_a), 32'(LOOKUP));
    chk("lkwr.enable", {31'b0, enable_a}, 32'd0);
    cfg_write(1'b0, 16'd5000, 0);
    chk("lkwr.enable_on", {31'b0, enable_a}, 32'd1);
    chk("lkwr.select", {31'b0, select_a}, 32'd0);
    chk("lkwr.drop", {31'b0, drop_a}, 32'd0);
    hdr_xfer();
    payload(1, 0, "lkwr");
    exp_q.push_back(4'b1001);
    open_hdr(16'd5000, "lkwr_next");
    hdr_xfer();
    payload(1, 0, "lkwr_next");
    exp_cnt_a++;
    chk("lkwr_next.count_a", drop_count_a, exp_cnt_a);

    // tlast before the header handshake is ignored; same-cycle handshake ends it
    cfg_write(1'b0, 16'd5000, 1);
    exp_q.push_back(4'b0000);
    open_hdr(16'd5000, "early");
    hdr_valid = 0;
    tvalid = 1; tready = 1; tlast = 1;
    step();
    chk("early.tlast_ignored", {31'b0, enable_a}, 32'd1);
    chk("early.state", 32'(state_a), 32'(ACTIVE));
    hdr_valid = 1; hdr_ready = 1;
    step();
    hdr_valid = 0; hdr_ready = 0; tvalid = 0; tready = 0; tlast = 0;
    chk("same_cycle.enable", {31'b0, enable_a}, 32'd0);
    chk("same_cycle.busy", {31'b0, busy_a}, 32'd0);

    // asynchronous reset in the middle of a dropped datagram
    exp_q.push_back(4'b1001);
    open_hdr(16'd7000, "rst_mid");
    hdr_xfer();
    tvalid = 1; tready = 1; tlast = 0;
    step();
    chk("rst_mid.drop_before", {31'b0, drop_a}, 32'd1);
    #2 reset_n = 0;
    #1;
    chk("rst_mid.enable", {31'b0, enable_a}, 32'd0);
    chk("rst_mid.drop", {31'b0, drop_a}, 32'd0);
    chk("rst_mid.select_b", {31'b0, select_b}, 32'd0);
    chk("rst_mid.busy", {31'b0, busy_a}, 32'd0);
    chk("rst_mid.count", drop_count_a, 32'd0);
    tvalid = 0; tready = 0;
    step(); step();
    reset_n = 1;
    step(); step(); step();
    exp_cnt_a = 0;
    exp_q.push_back(4'b1001);
    open_hdr(16'd5000, "post_rst");
    hdr_xfer();
    payload(2, 0, "post_rst");
    exp_cnt_a++;
    chk("post_rst.count_a", drop_count_a, exp_cnt_a);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
